// File: rtl/id_ex_stage_if.sv
// Decode-to-EX bundle for the ID/EX stage: decode fields, later-stage forwarding
// sources, and the operands/controls the stage hands to the ALU and memory stage.
interface id_ex_stage_if #(
    parameter int width      = 32,
    parameter int reg_addr_w = 5
);
    // Handshake: valid_i qualifies every decode field in the same cycle. There is
    // no ready; the decode side must hold PC and IF/ID while hazard_o is high, and
    // the stage itself holds its contents while stall_i is high.
    logic                  flush_i;
    logic                  stall_i;
    logic                  valid_i;
    logic [3:0]            ALUCtrl_i;
    logic                  ALUSrc_i;
    logic                  RegWrite_i;
    logic                  MemRead_i;
    logic                  MemWrite_i;
    logic                  MemtoReg_i;
    logic [reg_addr_w-1:0] rs1_addr_i;
    logic [reg_addr_w-1:0] rs2_addr_i;
    logic [reg_addr_w-1:0] rd_addr_i;
    logic [width-1:0]      rs1_data_i;
    logic [width-1:0]      rs2_data_i;
    logic [width-1:0]      imm_i;
    logic                  exmem_RegWrite_i;
    logic                  memwb_RegWrite_i;
    logic [reg_addr_w-1:0] exmem_rd_i;
    logic [reg_addr_w-1:0] memwb_rd_i;
    logic [width-1:0]      exmem_data_i;
    logic [width-1:0]      memwb_data_i;

    logic                  hazard_o;
    logic                  valid_o;
    logic [3:0]            ALUCtrl_o;
    logic [width-1:0]      data1_o;
    logic [width-1:0]      data2_o;
    logic [width-1:0]      store_data_o;
    logic [reg_addr_w-1:0] rd_addr_o;
    logic                  RegWrite_o;
    logic                  MemRead_o;
    logic                  MemWrite_o;
    logic                  MemtoReg_o;

    modport master (
        output flush_i, stall_i, valid_i, ALUCtrl_i, ALUSrc_i,
               RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i,
               rs1_addr_i, rs2_addr_i, rd_addr_i, rs1_data_i, rs2_data_i, imm_i,
               exmem_RegWrite_i, memwb_RegWrite_i, exmem_rd_i, memwb_rd_i,
               exmem_data_i, memwb_data_i,
        input  hazard_o, valid_o, ALUCtrl_o, data1_o, data2_o, store_data_o,
               rd_addr_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o
    );

    modport slave (
        input  flush_i, stall_i, valid_i, ALUCtrl_i, ALUSrc_i,
               RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i,
               rs1_addr_i, rs2_addr_i, rd_addr_i, rs1_data_i, rs2_data_i, imm_i,
               exmem_RegWrite_i, memwb_RegWrite_i, exmem_rd_i, memwb_rd_i,
               exmem_data_i, memwb_data_i,
        output hazard_o, valid_o, ALUCtrl_o, data1_o, data2_o, store_data_o,
               rd_addr_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-time operand forwarding and load-use bubble
// insertion, feeding the ALU operands and the downstream control bits.
module id_ex_stage #(
    parameter int width      = 32,
    parameter int reg_addr_w = 5
) (
    input logic         clk_i,
    input logic         rst_i,
    id_ex_stage_if.slave stage
);
    logic                  valid_q;
    logic [3:0]            alu_ctrl_q;
    logic                  alu_src_q;
    logic                  reg_write_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic                  memto_reg_q;
    logic [reg_addr_w-1:0] rs1_addr_q;
    logic [reg_addr_w-1:0] rs2_addr_q;
    logic [reg_addr_w-1:0] rd_addr_q;
    logic [width-1:0]      rs1_data_q;
    logic [width-1:0]      rs2_data_q;
    logic [width-1:0]      imm_q;

    logic                  hazard;
    logic                  bubble;
    logic [width-1:0]      rs1_fwd;
    logic [width-1:0]      rs2_fwd;

    // A load in the stage blocks any decode instruction naming its rd (x0 excluded).
    assign hazard = valid_q & mem_read_q & (rd_addr_q != '0) & stage.valid_i &
                    ((rd_addr_q == stage.rs1_addr_i) | (rd_addr_q == stage.rs2_addr_i));

    // Flush beats stall; stall beats the load-use bubble.
    assign bubble = stage.flush_i | (~stage.stall_i & hazard);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q     <= 1'b0;
            alu_ctrl_q  <= '0;
            alu_src_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            memto_reg_q <= 1'b0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_addr_q   <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
        end else if (bubble) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            memto_reg_q <= 1'b0;
        end else if (!stage.stall_i) begin
            valid_q     <= stage.valid_i;
            alu_ctrl_q  <= stage.ALUCtrl_i;
            alu_src_q   <= stage.ALUSrc_i;
            reg_write_q <= stage.RegWrite_i;
            mem_read_q  <= stage.MemRead_i;
            mem_write_q <= stage.MemWrite_i;
            memto_reg_q <= stage.MemtoReg_i;
            rs1_addr_q  <= stage.rs1_addr_i;
            rs2_addr_q  <= stage.rs2_addr_i;
            rd_addr_q   <= stage.rd_addr_i;
            rs1_data_q  <= stage.rs1_data_i;
            rs2_data_q  <= stage.rs2_data_i;
            imm_q       <= stage.imm_i;
        end
    end

    // EX/MEM is the younger result, so it takes priority over MEM/WB.
    always_comb begin
        rs1_fwd = rs1_data_q;
        if (valid_q & stage.exmem_RegWrite_i & (stage.exmem_rd_i != '0) &
            (stage.exmem_rd_i == rs1_addr_q))
            rs1_fwd = stage.exmem_data_i;
        else if (valid_q & stage.memwb_RegWrite_i & (stage.memwb_rd_i != '0) &
                 (stage.memwb_rd_i == rs1_addr_q))
            rs1_fwd = stage.memwb_data_i;
    end

    always_comb begin
        rs2_fwd = rs2_data_q;
        if (valid_q & stage.exmem_RegWrite_i & (stage.exmem_rd_i != '0) &
            (stage.exmem_rd_i == rs2_addr_q))
            rs2_fwd = stage.exmem_data_i;
        else if (valid_q & stage.memwb_RegWrite_i & (stage.memwb_rd_i != '0) &
                 (stage.memwb_rd_i == rs2_addr_q))
            rs2_fwd = stage.memwb_data_i;
    end

    assign stage.hazard_o     = hazard;
    assign stage.valid_o      = valid_q;
    assign stage.ALUCtrl_o    = alu_ctrl_q;
    assign stage.data1_o      = rs1_fwd;
    assign stage.data2_o      = alu_src_q ? imm_q : rs2_fwd;
    assign stage.store_data_o = rs2_fwd;
    assign stage.rd_addr_o    = rd_addr_q;
    assign stage.RegWrite_o   = valid_q & reg_write_q;
    assign stage.MemRead_o    = valid_q & mem_read_q;
    assign stage.MemWrite_o   = valid_q & mem_write_q;
    assign stage.MemtoReg_o   = valid_q & memto_reg_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage: table of decode/forwarding inputs with
// hand-computed outputs, plus a hand-written mid-stall asynchronous reset.
module tb_id_ex_stage;
    localparam logic [3:0] alu_and = 4'b0000;
    localparam logic [3:0] alu_or  = 4'b0001;
    localparam logic [3:0] alu_add = 4'b0010;
    localparam logic [3:0] alu_sub = 4'b0110;

    typedef struct packed {
        logic        flush, stall, valid;
        logic [3:0]  alu;
        logic        src, rw, mr, mw;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic        ex_rw;
        logic [4:0]  ex_rd;
        logic [31:0] ex_d;
        logic        wb_rw;
        logic [4:0]  wb_rd;
        logic [31:0] wb_d;
        logic        chk, e_haz, e_valid, e_rw, e_mr, e_mw;
        logic [3:0]  e_alu;
        logic [4:0]  e_rd;
        logic [31:0] e_d1, e_d2, e_st;
    } vec_t;

    logic clk;
    logic rst;
    int   n_applied = 0;
    int   n_miss = 0;
    vec_t tbl[$];

    id_ex_stage_if #(.width(32), .reg_addr_w(5)) bus ();

    id_ex_stage #(.width(32), .reg_addr_w(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .stage (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t ins(input logic v, input logic [3:0] alu, input logic src,
                                 input logic rw, input logic mr, input logic mw,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [31:0] imm);
        vec_t t;
        t = '0;
        t.valid = v; t.alu = alu; t.src = src; t.rw = rw; t.mr = mr; t.mw = mw;
        t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.d1 = d1; t.d2 = d2; t.imm = imm;
        return t;
    endfunction

    function automatic vec_t with_fwd(input vec_t t, input logic ex_rw,
                                      input logic [4:0] ex_rd, input logic [31:0] ex_d,
                                      input logic wb_rw, input logic [4:0] wb_rd,
                                      input logic [31:0] wb_d);
        vec_t r;
        r = t;
        r.ex_rw = ex_rw; r.ex_rd = ex_rd; r.ex_d = ex_d;
        r.wb_rw = wb_rw; r.wb_rd = wb_rd; r.wb_d = wb_d;
        return r;
    endfunction

    function automatic vec_t with_ctl(input vec_t t, input logic flush, input logic stall);
        vec_t r;
        r = t;
        r.flush = flush; r.stall = stall;
        return r;
    endfunction

    function automatic vec_t exp_ok(input vec_t t, input logic haz, input logic rw,
                                    input logic mr, input logic mw, input logic [3:0] alu,
                                    input logic [4:0] rd, input logic [31:0] d1,
                                    input logic [31:0] d2, input logic [31:0] st);
        vec_t r;
        r = t;
        r.chk = 1'b1; r.e_haz = haz; r.e_valid = 1'b1;
        r.e_rw = rw; r.e_mr = mr; r.e_mw = mw; r.e_alu = alu; r.e_rd = rd;
        r.e_d1 = d1; r.e_d2 = d2; r.e_st = st;
        return r;
    endfunction

    function automatic vec_t exp_bub(input vec_t t, input logic haz);
        vec_t r;
        r = t;
        r.chk = 1'b0; r.e_haz = haz; r.e_valid = 1'b0;
        r.e_rw = 1'b0; r.e_mr = 1'b0; r.e_mw = 1'b0;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver: called just after a falling edge
    task automatic drive(input vec_t v);
        bus.flush_i          = v.flush;
        bus.stall_i          = v.stall;
        bus.valid_i          = v.valid;
        bus.ALUCtrl_i        = v.alu;
        bus.ALUSrc_i         = v.src;
        bus.RegWrite_i       = v.rw;
        bus.MemRead_i        = v.mr;
        bus.MemWrite_i       = v.mw;
        bus.MemtoReg_i       = v.mr;
        bus.rs1_addr_i       = v.rs1;
        bus.rs2_addr_i       = v.rs2;
        bus.rd_addr_i        = v.rd;
        bus.rs1_data_i       = v.d1;
        bus.rs2_data_i       = v.d2;
        bus.imm_i            = v.imm;
        bus.exmem_RegWrite_i = v.ex_rw;
        bus.exmem_rd_i       = v.ex_rd;
        bus.exmem_data_i     = v.ex_d;
        bus.memwb_RegWrite_i = v.wb_rw;
        bus.memwb_rd_i       = v.wb_rd;
        bus.memwb_data_i     = v.wb_d;
    endtask

    task automatic apply(input vec_t v, input int idx);
        drive(v);
        #1;
        check($sformatf("v%0d_hazard", idx), {31'b0, bus.hazard_o}, {31'b0, v.e_haz});
        @(posedge clk);
        #1;
        check($sformatf("v%0d_valid", idx), {31'b0, bus.valid_o}, {31'b0, v.e_valid});
        check($sformatf("v%0d_regwrite", idx), {31'b0, bus.RegWrite_o}, {31'b0, v.e_rw});
        check($sformatf("v%0d_memread", idx), {31'b0, bus.MemRead_o}, {31'b0, v.e_mr});
        check($sformatf("v%0d_memwrite", idx), {31'b0, bus.MemWrite_o}, {31'b0, v.e_mw});
        if (v.chk) begin
            check($sformatf("v%0d_memtoreg", idx), {31'b0, bus.MemtoReg_o}, {31'b0, v.e_mr});
            check($sformatf("v%0d_aluctrl", idx), {28'b0, bus.ALUCtrl_o}, {28'b0, v.e_alu});
            check($sformatf("v%0d_rd", idx), {27'b0, bus.rd_addr_o}, {27'b0, v.e_rd});
            check($sformatf("v%0d_data1", idx), bus.data1_o, v.e_d1);
            check($sformatf("v%0d_data2", idx), bus.data2_o, v.e_d2);
            check($sformatf("v%0d_store", idx), bus.store_data_o, v.e_st);
        end
    endtask

    initial begin
        vec_t s, lw6, stl;

        // reset with arbitrary inputs; x0 forwarding source must not leak through
        rst = 1'b1;
        drive(with_fwd(ins(1, alu_sub, 0, 1, 1, 1, 0, 0, 9, 'h1234, 'h5678, 'h9),
                       1, 0, 'hFFFF, 1, 0, 'hEEEE));
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_valid", {31'b0, bus.valid_o}, 32'd0);
        check("rst_regwrite", {31'b0, bus.RegWrite_o}, 32'd0);
        check("rst_aluctrl", {28'b0, bus.ALUCtrl_o}, 32'd0);
        check("rst_data1", bus.data1_o, 32'd0);
        check("rst_data2", bus.data2_o, 32'd0);
        check("rst_hazard", {31'b0, bus.hazard_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        tbl.push_back(exp_ok(ins(1, alu_add, 0, 1, 0, 0, 1, 2, 3, 5, 7, 0),
                             0, 1, 0, 0, alu_add, 3, 5, 7, 7));
        tbl.push_back(exp_ok(ins(1, alu_add, 1, 1, 0, 0, 3, 9, 6, 'h100, 9, 'hFFFFFFFC),
                             0, 1, 0, 0, alu_add, 6, 'h100, 'hFFFFFFFC, 9));
        s = ins(1, alu_sub, 0, 1, 0, 0, 3, 4, 7, 'hAAAA, 3, 0);
        tbl.push_back(exp_ok(with_fwd(s, 1, 3, 'h11, 1, 3, 'h22), 0, 1, 0, 0, alu_sub, 7, 'h11, 3, 3));
        tbl.push_back(exp_ok(with_fwd(s, 0, 3, 'h11, 1, 3, 'h22), 0, 1, 0, 0, alu_sub, 7, 'h22, 3, 3));
        tbl.push_back(exp_ok(with_fwd(s, 1, 0, 'h11, 1, 0, 'h22), 0, 1, 0, 0, alu_sub, 7, 'hAAAA, 3, 3));
        tbl.push_back(exp_ok(with_fwd(ins(1, alu_and, 0, 1, 0, 0, 1, 5, 8, 'hF0, 'h0F, 0),
                                      1, 9, 'h33, 1, 5, 'h44),
                             0, 1, 0, 0, alu_and, 8, 'hF0, 'h44, 'h44));
        tbl.push_back(exp_ok(with_fwd(ins(1, alu_add, 1, 0, 0, 1, 1, 5, 8, 'h1000, 'h55, 8),
                                      1, 5, 'h66, 1, 5, 'h77),
                             0, 0, 0, 1, alu_add, 8, 'h1000, 8, 'h66));
        // lw x4 then dependent add: one bubble, then MEM/WB supplies x4
        tbl.push_back(exp_ok(ins(1, alu_add, 1, 1, 1, 0, 1, 0, 4, 'h2000, 0, 0),
                             0, 1, 1, 0, alu_add, 4, 'h2000, 0, 0));
        s = ins(1, alu_add, 0, 1, 0, 0, 4, 1, 5, 'hDEAD, 3, 0);
        tbl.push_back(exp_bub(s, 1));
        tbl.push_back(exp_ok(with_fwd(s, 0, 0, 0, 1, 4, 'h99), 0, 1, 0, 0, alu_add, 5, 'h99, 3, 3));
        // load to x0 never stalls, and x0 never forwards
        tbl.push_back(exp_ok(ins(1, alu_add, 1, 1, 1, 0, 2, 0, 0, 'h10, 0, 0),
                             0, 1, 1, 0, alu_add, 0, 'h10, 0, 0));
        tbl.push_back(exp_ok(with_fwd(ins(1, alu_or, 0, 1, 0, 0, 0, 0, 7, 0, 0, 0),
                                      1, 0, 'h5A, 1, 0, 'h5B),
                             0, 1, 0, 0, alu_or, 7, 0, 0, 0));
        lw6 = exp_ok(ins(1, alu_add, 1, 1, 1, 0, 1, 0, 6, 'h300, 0, 4),
                     0, 1, 1, 0, alu_add, 6, 'h300, 4, 0);
        tbl.push_back(lw6);
        tbl.push_back(exp_bub(ins(0, alu_add, 0, 1, 1, 1, 6, 6, 9, 1, 2, 3), 0));
        tbl.push_back(lw6);
        tbl.push_back(exp_bub(ins(1, alu_add, 0, 1, 0, 0, 1, 6, 9, 1, 2, 0), 1));
        tbl.push_back(lw6);
        tbl.push_back(exp_bub(with_ctl(ins(1, alu_add, 0, 1, 0, 0, 6, 1, 9, 1, 2, 0), 1, 0), 1));
        // stall holds for three cycles, then flush+stall yields a bubble
        tbl.push_back(exp_ok(ins(1, alu_add, 0, 1, 0, 0, 1, 2, 3, 'h123, 'h456, 0),
                             0, 1, 0, 0, alu_add, 3, 'h123, 'h456, 'h456));
        stl = ins(1, alu_sub, 1, 0, 1, 1, 3, 3, 10, 'hEEE, 'hFFF, 1);
        for (int i = 0; i < 3; i++)
            tbl.push_back(exp_ok(with_ctl(stl, 0, 1), 0, 1, 0, 0, alu_add, 3, 'h123, 'h456, 'h456));
        tbl.push_back(exp_bub(with_ctl(stl, 1, 1), 0));

        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i], i);
        end

        // asynchronous reset while stalled with a valid instruction
        @(negedge clk);
        drive(ins(1, alu_add, 0, 1, 0, 0, 1, 2, 3, 'h77, 'h88, 0));
        @(posedge clk);
        #1;
        check("pre_rst_valid", {31'b0, bus.valid_o}, 32'd1);
        check("pre_rst_data1", bus.data1_o, 32'h77);
        @(negedge clk);
        bus.stall_i = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", {31'b0, bus.valid_o}, 32'd0);
        check("async_rst_regwrite", {31'b0, bus.RegWrite_o}, 32'd0);
        check("async_rst_aluctrl", {28'b0, bus.ALUCtrl_o}, 32'd0);
        check("async_rst_data1", bus.data1_o, 32'd0);
        check("async_rst_data2", bus.data2_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.stall_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the ALU in the pipelined RISC-V core.
- Registers decoded operands, immediate, ALU control and downstream control bits from the decode stage.
- Resolves EX-time operand forwarding from the EX/MEM and MEM/WB stages, then presents final data1/data2/ALUCtrl to the ALU.
- Detects load-use hazards and inserts bubbles.

Parameters:
- width, 32, datapath width of operands, immediate and forwarded results.
- reg_addr_w, 5, register address width.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- flush_i  input  1  kill the instruction entering the stage (branch/jump redirect).
- stall_i  input  1  downstream stall; hold the stage contents.
- valid_i  input  1  decode stage presents a real instruction.
- ALUCtrl_i  input  4  ALU operation code from ALU control.
- ALUSrc_i  input  1  1: operand 2 = immediate; 0: operand 2 = rs2 data.
- RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i  input  1 each  control bits passed downstream.
- rs1_addr_i, rs2_addr_i, rd_addr_i  input  reg_addr_w  register addresses of the decode instruction.
- rs1_data_i, rs2_data_i, imm_i  input  width  register-file read data and sign-extended immediate.
- exmem_RegWrite_i, memwb_RegWrite_i  input  1  write enables of the later stages.
- exmem_rd_i, memwb_rd_i  input  reg_addr_w  destination registers of the later stages.
- exmem_data_i, memwb_data_i  input  width  results available for forwarding.
- hazard_o  output  1  load-use hazard; combinational; upstream must hold PC and IF/ID.
- valid_o  output  1  stage holds a real instruction.
- ALUCtrl_o  output  4  to ALU ALUCtrl_i.
- data1_o, data2_o  output  width  to ALU data1_i, data2_i.
- store_data_o  output  width  forwarded rs2 value for stores.
- rd_addr_o  output  reg_addr_w  registered rd.
- RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o  output  1 each  registered controls, gated by valid.

Behaviour:
- Reset (async, rst_i=1): all stage registers clear to 0, so valid_o=0, all controls 0, ALUCtrl_o=0 and rd_addr_o=0. Operand registers also clear to 0, so data1_o and data2_o read 0 unless forwarding applies; forwarding is gated by valid, so they read 0.
- Latency: one cycle from decode inputs to ALUCtrl_o and the registered fields. data1_o, data2_o and store_data_o are combinational from the stage registers plus the forwarding inputs in the same cycle.
- hazard_o = stage valid & MemRead & (rd != 0) & valid_i & ((rd == rs1_addr_i) | (rd == rs2_addr_i)).
- Rising-edge update priority, highest first:
  - flush_i: load a bubble (valid=0, all controls 0, other fields don't-care).
  - stall_i: hold every register.
  - hazard_o: load a bubble.
  - Otherwise: capture all *_i, with valid = valid_i.
- Bubble controls: RegWrite_o, MemRead_o and MemWrite_o are forced 0 whenever the stage is invalid, so no side effects occur.
- Forwarding for rs1; rs2 uses the same rules:
  - If valid & exmem_RegWrite_i & exmem_rd_i != 0 & exmem_rd_i == rs1, use exmem_data_i.
  - Else if valid & memwb_RegWrite_i & memwb_rd_i != 0 & memwb_rd_i == rs1, use memwb_data_i.
  - Else use the registered rs1 data.
  - EX/MEM always wins over MEM/WB. x0 never forwards.
- data2_o = registered ALUSrc ? registered imm : forwarded rs2. store_data_o is always the forwarded rs2.
- Load-use hazard: on the cycle hazard_o=1, the stage becomes a bubble on the next edge. The load then sits in EX/MEM, and the dependent instruction enters the cycle after with MEM/WB forwarding supplying the data. One bubble per load-use pair.
- Simultaneous flush_i and hazard_o: flush wins. hazard_o is still asserted combinationally; the redirect logic owns the PC.
- Reset asserted mid-stall: clears immediately and asynchronously; the stall is irrelevant.

Test Plan:
- Reset: rst_i=1 with arbitrary inputs -> valid_o=0, RegWrite_o=0, ALUCtrl_o=0, data1_o=0. Release reset, present ADD with rs1_data=5, rs2_data=7, ALUSrc=0 -> next cycle data1_o=5, data2_o=7, ALUCtrl_o=ADD, valid_o=1.
- Immediate select: ALUSrc=1, imm=0xFFFFFFFC, rs2_data=9 -> data2_o=0xFFFFFFFC, store_data_o=9.
- Forward priority: stage rs1=x3; exmem_rd=3 with data 0x11; memwb_rd=3 with data 0x22, both RegWrite=1 -> data1_o=0x11. Drop exmem_RegWrite -> 0x22. Set both rd=0 -> registered value.
- Load-use: stage holds lw x4 (MemRead=1); decode presents add x5,x4,x1 -> hazard_o=1; the next edge yields valid_o=0 with RegWrite_o=0; the following edge captures add.
- Stall/flush: stall_i=1 for 3 cycles -> all outputs frozen. flush_i=1 together with stall_i=1 -> valid_o=0 after the edge.
- Async reset mid-pipeline: assert rst_i between edges while valid_o=1 -> valid_o=0 immediately, without waiting for clk_i.
